// File: rtl/vga_sync_module.sv
// Purpose : 640x480@60Hz VGA timing generator advancing one pixel per pix_ce cycle;
//           produces hsync/vsync/video_on, pixel coordinates and a frame-start pulse.
// Latency : all outputs registered; frame_start rises on the edge counters enter (0,0).
// Backpressure: none, timing free-runs; pix_ce=0 freezes position and sync levels.
// Ports   : clk_in, rst (sync, active-high), pix_ce | hsync, vsync, video_on,
//           pixel_x[9:0], pixel_y[9:0], frame_start, frame_cnt[15:0] (optional).
// Option  : define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame_cnt output, which
//           counts frame_start pulses since reset and wraps at 65535.
module vga_sync_module #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_sync_module: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end
  endgenerate

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Decode bounds kept 11 bits wide so an end bound of exactly 1024 cannot alias.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        hs_act;
  logic        vs_act;
  logic        vid_nxt;
  logic        enter_origin;

  always_comb begin
    x_nxt = pixel_x;
    y_nxt = pixel_y;
    if (pix_ce) begin
      if (pixel_x == H_LAST) begin
        x_nxt = 10'd0;
        y_nxt = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        x_nxt = pixel_x + 10'd1;
      end
    end
  end

  // Decode from the next-state counts so the registered sync/video flags line
  // up with the registered coordinates they describe.
  always_comb begin
    x_ext        = {1'b0, x_nxt};
    y_ext        = {1'b0, y_nxt};
    hs_act       = (x_ext >= HS_BEG) && (x_ext < HS_END);
    vs_act       = (y_ext >= VS_BEG) && (y_ext < VS_END);
    vid_nxt      = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    // Only a wrap on a ce cycle lands on the origin; holding at (0,0) must not retrigger.
    enter_origin = pix_ce && (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
      video_on    <= vid_nxt;
      frame_start <= enter_origin;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (enter_origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: full-size timing instance for reset, line and hold behaviour;
// a shrunken-timing instance (15x10 pixels, active-high sync) for frame-level
// behaviour so whole frames fit in a short run.
module tb_vga_sync_module;

  logic       clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // full-size instance
  logic       rst, ce;
  logic       hs, vs, vo, fs;
  logic [9:0] px, py;
  // small instance: H 8+2+3+2=15, V 6+1+2+1=10, SYNC_POL=1
  logic       rst_s, ce_s;
  logic       hs_s, vs_s, vo_s, fs_s;
  logic [9:0] px_s, py_s;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fc, fc_s;
`endif

  vga_sync_module dut (
    .clk_in(clk_in), .rst(rst), .pix_ce(ce),
    .hsync(hs), .vsync(vs), .video_on(vo),
    .pixel_x(px), .pixel_y(py), .frame_start(fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(fc)
`endif
  );

  vga_sync_module #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk_in(clk_in), .rst(rst_s), .pix_ce(ce_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(vo_s),
    .pixel_x(px_s), .pixel_y(py_s), .frame_start(fs_s)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  // Reference position for the small instance, stepped by the bench.
  int ex, ey, serr, fs_cnt, fs_first, fs_last, vs_cycles;

  task automatic s_step(input bit ce_now, input int n);
    bit fs_exp;
    fs_exp = 1'b0;
    if (ce_now) begin
      if (ex == 14) begin
        ex = 0;
        ey = (ey == 9) ? 0 : ey + 1;
        fs_exp = (ey == 0);
      end else begin
        ex = ex + 1;
      end
    end
    if (px_s !== 10'(ex)) serr++;
    if (py_s !== 10'(ey)) serr++;
    if (hs_s !== ((ex >= 10 && ex < 13) ? 1'b1 : 1'b0)) serr++;
    if (vs_s !== ((ey >= 7 && ey < 9) ? 1'b1 : 1'b0)) serr++;
    if (vo_s !== ((ex < 8 && ey < 6) ? 1'b1 : 1'b0)) serr++;
    if (fs_s !== fs_exp) serr++;
    if (vs_s === 1'b1) vs_cycles++;
    if (fs_s === 1'b1) begin
      if (fs_cnt == 0) fs_first = n; else fs_last = n;
      fs_cnt++;
    end
  endtask

  task automatic s_clear();
    serr = 0; fs_cnt = 0; fs_first = -1; fs_last = -1; vs_cycles = 0;
  endtask

  initial begin
    int herr, hs_low, hs_first;
    rst = 1'b1; ce = 1'b1; rst_s = 1'b1; ce_s = 1'b1;
    cyc(); cyc();

    // 1: reset state, full size
    check("rst_x", px, 32'd799);
    check("rst_y", py, 32'd524);
    check("rst_vo", vo, 32'd0);
    check("rst_hs", hs, 32'd1);
    check("rst_vs", vs, 32'd1);
    check("rst_fs", fs, 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("rst_fc", fc, 32'd0);
`endif

    // 2: release -> origin after one edge, one-cycle frame_start
    rst = 1'b0;
    cyc();
    check("org_x", px, 32'd0);
    check("org_y", py, 32'd0);
    check("org_vo", vo, 32'd1);
    check("org_fs", fs, 32'd1);
    check("org_hs", hs, 32'd1);

    // 3: rest of line 0, hsync only at 656..751, video_on only below 640
    herr = 0; hs_low = 0; hs_first = -1;
    for (int i = 1; i < 800; i++) begin
      cyc();
      if (px !== 10'(i) || py !== 10'd0) herr++;
      if (hs !== ((i >= 656 && i < 752) ? 1'b0 : 1'b1)) herr++;
      if (vo !== ((i < 640) ? 1'b1 : 1'b0)) herr++;
      if (fs !== 1'b0) herr++;
      if (vs !== 1'b1) herr++;
      if (hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
    end
    check("line_err", herr, 32'd0);
    check("hs_low_cycles", hs_low, 32'd96);
    check("hs_first_x", hs_first, 32'd656);
    cyc();
    check("l1_x", px, 32'd0);
    check("l1_y", py, 32'd1);
    check("l1_fs", fs, 32'd0);

    // pix_ce low: everything holds
    ce = 1'b0;
    cyc(); cyc(); cyc();
    check("hold_x", px, 32'd0);
    check("hold_y", py, 32'd1);
    check("hold_vo", vo, 32'd1);
    check("hold_fs", fs, 32'd0);
    ce = 1'b1;
    repeat (300) cyc();
    check("run_x", px, 32'd300);
    check("run_y", py, 32'd1);

    // mid-frame reset, rst wins over pix_ce
    rst = 1'b1;
    cyc();
    check("mrst_x", px, 32'd799);
    check("mrst_y", py, 32'd524);
    check("mrst_vo", vo, 32'd0);
    check("mrst_hs", hs, 32'd1);
    rst = 1'b0;

    // small instance: reset state (active-high sync -> inactive 0)
    check("s_rst_x", px_s, 32'd14);
    check("s_rst_y", py_s, 32'd9);
    check("s_rst_hs", hs_s, 32'd0);
    check("s_rst_vs", vs_s, 32'd0);
    check("s_rst_fs", fs_s, 32'd0);

    // 4: two frames with pix_ce=1
    rst_s = 1'b0; ex = 14; ey = 9; s_clear();
    for (int n = 0; n < 300; n++) begin
      cyc();
      s_step(1'b1, n);
    end
    check("s_frame_err", serr, 32'd0);
    check("s_fs_count", fs_cnt, 32'd2);
    check("s_fs_first", fs_first, 32'd0);
    check("s_fs_period", fs_last - fs_first, 32'd150);
    check("s_vs_cycles", vs_cycles, 32'd60);

    // 5: pix_ce alternating -> double frame period, frame_start one cycle
    s_clear();
    for (int n = 0; n < 600; n++) begin
      ce_s = (n % 2 == 0);
      cyc();
      s_step(ce_s, n);
    end
    check("s_alt_err", serr, 32'd0);
    check("s_alt_fs_count", fs_cnt, 32'd2);
    check("s_alt_period", fs_last - fs_first, 32'd300);

    // 6: reset pulse mid-frame at (5,3)
    ce_s = 1'b1;
    repeat (51) cyc();
    check("s_pos_x", px_s, 32'd5);
    check("s_pos_y", py_s, 32'd3);
    rst_s = 1'b1;
    cyc();
    check("s_mrst_x", px_s, 32'd14);
    check("s_mrst_y", py_s, 32'd9);
    check("s_mrst_fs", fs_s, 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("s_mrst_fc", fc_s, 32'd0);
`endif
    rst_s = 1'b0; ex = 14; ey = 9; s_clear();
    for (int n = 0; n < 300; n++) begin
      cyc();
      s_step(1'b1, n);
    end
    check("s_post_err", serr, 32'd0);
    check("s_post_fs_count", fs_cnt, 32'd2);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("s_fc_two", fc_s, 32'd2);
    ce_s = 1'b0;
    force dut_s.frame_cnt = 16'hFFFF;
    cyc();
    release dut_s.frame_cnt;
    check("s_fc_forced", fc_s, 32'd65535);
    ce_s = 1'b1;
    cyc();
    check("s_fc_wrap_fs", fs_s, 32'd1);
    check("s_fc_wrap", fc_s, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
